// File: rtl/move_scheduler_pkg.sv
// Shared constants, FSM encoding and saturating step helper for the sprite movement controller.
package move_scheduler_pkg;

    localparam logic [9:0] STEP        = 10'd2;
    localparam logic [9:0] X_MAX       = 10'd624;
    localparam logic [9:0] Y_MAX       = 10'd464;
    localparam logic [9:0] START_X     = 10'd16;
    localparam logic [9:0] START_Y     = 10'd16;
    localparam logic [9:0] SPRITE_EDGE = 10'd15;
    localparam int         TILE_SHIFT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAND   = 2'd1,
        ST_PROBE  = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    // One STEP toward zero or toward pos_max, clamped at the ends of the playfield.
    function automatic logic [9:0] step_pos(input logic [9:0] pos,
                                            input logic       toward_zero,
                                            input logic [9:0] pos_max);
        logic [9:0] res;
        if (toward_zero)
            res = (pos < STEP) ? 10'd0 : pos - STEP;
        else
            res = (pos > pos_max - STEP) ? pos_max : pos + STEP;
        return res;
    endfunction

endpackage

// File: rtl/move_scheduler_tile_addr_calc.sv
// Pixel (x,y) to tile-map index; row*40 is built from two shifts.
module move_scheduler_tile_addr_calc
    import move_scheduler_pkg::*;
(
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    output logic [10:0] o_addr
);

    logic [5:0] w_col;
    logic [5:0] w_row;
    logic       w_unused_lsb;

    assign w_col  = i_x[9:TILE_SHIFT];
    assign w_row  = i_y[9:TILE_SHIFT];
    assign o_addr = {w_row, 5'b0} + {2'b0, w_row, 3'b0} + {5'b0, w_col};

    assign w_unused_lsb = ^{i_x[TILE_SHIFT-1:0], i_y[TILE_SHIFT-1:0]};

endmodule

// File: rtl/move_scheduler.sv
// Once-per-frame sprite step with four-corner wall probe; renderer has priority on the tile port.
//  state  | meaning
//  IDLE   | waiting for frame_tick with a button held
//  CAND   | candidate latched; drop out if saturation left it unchanged
//  PROBE  | issue corner reads when renderer is idle, watch returning wall bits
//  DECIDE | commit candidate unless a wall was seen
module move_scheduler
    import move_scheduler_pkg::*;
(
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        vid_req,
    input  logic [10:0] vid_addr,
    output logic        vid_grant,
    output logic [10:0] tile_addr,
    input  logic        tile_wall,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  r_cand_x;
    logic [9:0]  r_cand_y;
    logic [1:0]  r_probe_idx;
    logic        r_inflight;
    logic        r_wall_seen;
    logic        w_any_btn;
    logic        w_wall_now;
    logic        w_issue;
    logic [9:0]  w_corner_x;
    logic [9:0]  w_corner_y;
    logic [10:0] w_probe_addr;

    assign w_any_btn  = btn_up | btn_down | btn_left | btn_right;
    assign w_wall_now = r_inflight & tile_wall;
    assign w_issue    = (r_state == ST_PROBE) & ~vid_req & ~w_wall_now;

    // Probe index bit 0 selects the right edge, bit 1 the bottom edge.
    assign w_corner_x = r_cand_x + (r_probe_idx[0] ? SPRITE_EDGE : 10'd0);
    assign w_corner_y = r_cand_y + (r_probe_idx[1] ? SPRITE_EDGE : 10'd0);

    move_scheduler_tile_addr_calc u_addr_calc (
        .i_x    (w_corner_x),
        .i_y    (w_corner_y),
        .o_addr (w_probe_addr)
    );

    assign vid_grant = vid_req;
    assign tile_addr = vid_req ? vid_addr : w_probe_addr;
    assign x_pos     = r_x;
    assign y_pos     = r_y;
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (frame_tick && w_any_btn) w_state_nxt = ST_CAND;
            ST_CAND:   w_state_nxt = (r_cand_x == r_x && r_cand_y == r_y) ? ST_IDLE : ST_PROBE;
            ST_PROBE:  if (w_wall_now || (w_issue && r_probe_idx == 2'd3)) w_state_nxt = ST_DECIDE;
            ST_DECIDE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_x         <= START_X;
            r_y         <= START_Y;
            r_cand_x    <= 10'd0;
            r_cand_y    <= 10'd0;
            r_probe_idx <= 2'd0;
            r_inflight  <= 1'b0;
            r_wall_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick && w_any_btn) begin
                        r_cand_x    <= r_x;
                        r_cand_y    <= r_y;
                        r_probe_idx <= 2'd0;
                        r_wall_seen <= 1'b0;
                        if (btn_up)
                            r_cand_y <= step_pos(r_y, 1'b1, Y_MAX);
                        else if (btn_down)
                            r_cand_y <= step_pos(r_y, 1'b0, Y_MAX);
                        else if (btn_left)
                            r_cand_x <= step_pos(r_x, 1'b1, X_MAX);
                        else
                            r_cand_x <= step_pos(r_x, 1'b0, X_MAX);
                    end
                end
                ST_PROBE: begin
                    if (w_issue)
                        r_probe_idx <= r_probe_idx + 2'd1;
                    if (w_wall_now)
                        r_wall_seen <= 1'b1;
                end
                ST_DECIDE: begin
                    // The last corner's data arrives in this cycle, so fold it in directly.
                    if (!r_wall_seen && !w_wall_now) begin
                        r_x <= r_cand_x;
                        r_y <= r_cand_y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
